// File: rtl/regfile_sb.sv
// Dual-write, dual-read integer register file with a per-register busy/tag
// scoreboard. Reads forward same-cycle committing writebacks.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss,
  input  logic [AW-1:0]   ia,
  input  logic [TAGW-1:0] it,
  input  logic            fl,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wn0,
  input  logic [TAGW-1:0] wt0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wn1,
  input  logic [TAGW-1:0] wt1,
  input  logic            re1,
  input  logic [AW-1:0]   ra1,
  input  logic            re2,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rn1,
  output logic [XLEN-1:0] rn2,
  output logic            rb1,
  output logic            rb2,
  output logic [TAGW-1:0] rt1,
  output logic [TAGW-1:0] rt2,
  output logic [AW:0]     nbusy
);

  logic [XLEN-1:0] r   [NREG];
  logic [TAGW-1:0] t   [NREG];
  logic [NREG-1:0] b;
  logic [XLEN-1:0] r_n [NREG];
  logic [TAGW-1:0] t_n [NREG];
  logic [NREG-1:0] b_n;
  logic            c0, c1;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + {{AW{1'b0}}, v[i]};
    return cnt;
  endfunction

  // A writeback commits unless its register waits on a different producer.
  always_comb begin
    c0 = we0 && (wa0 != '0) && (!b[wa0] || (t[wa0] == wt0));
    c1 = we1 && (wa1 != '0) && (!b[wa1] || (t[wa1] == wt1));
  end

  always_comb begin
    r_n = r;
    t_n = t;
    b_n = b;
    if (c0) begin
      r_n[wa0] = wn0;
      b_n[wa0] = 1'b0;
    end
    if (c1) begin
      r_n[wa1] = wn1;
      b_n[wa1] = 1'b0;
    end
    if (fl) b_n = '0;
    // Issue is applied last so it beats any same-cycle clear of its entry.
    if (iss && (ia != '0)) begin
      b_n[ia] = 1'b1;
      t_n[ia] = it;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r[i] <= '0;
        t[i] <= '0;
      end
      b     <= '0;
      nbusy <= '0;
    end else begin
      r     <= r_n;
      t     <= t_n;
      b     <= b_n;
      nbusy <= popcount(b_n);
    end
  end

  always_comb begin
    rn1 = '0;
    rb1 = 1'b0;
    rt1 = '0;
    if (!rst && re1) begin
      rn1 = r[ra1];
      if (c0 && (wa0 == ra1)) rn1 = wn0;
      if (c1 && (wa1 == ra1)) rn1 = wn1;
      rb1 = b[ra1] && !((c0 && (wa0 == ra1)) || (c1 && (wa1 == ra1)));
      rt1 = rb1 ? t[ra1] : '0;
    end
  end

  always_comb begin
    rn2 = '0;
    rb2 = 1'b0;
    rt2 = '0;
    if (!rst && re2) begin
      rn2 = r[ra2];
      if (c0 && (wa0 == ra2)) rn2 = wn0;
      if (c1 && (wa1 == ra2)) rn2 = wn1;
      rb2 = b[ra2] && !((c0 && (wa0 == ra2)) || (c1 && (wa1 == ra2)));
      rt2 = rb2 ? t[ra2] : '0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values queued with each stimulus
// step and checked against DUT outputs at the following falling edge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst, iss, fl, we0, we1, re1, re2;
  logic [4:0]  ia, wa0, wa1, ra1, ra2;
  logic [3:0]  it, wt0, wt1;
  logic [31:0] wn0, wn1;
  logic [31:0] rn1, rn2;
  logic        rb1, rb2;
  logic [3:0]  rt1, rt2;
  logic [5:0]  nbusy;

  int total = 0;
  int bad   = 0;
  string       tq[$];
  logic [31:0] eq[$];

  regfile_sb dut (
    .clk(clk), .rst(rst), .iss(iss), .ia(ia), .it(it), .fl(fl),
    .we0(we0), .wa0(wa0), .wn0(wn0), .wt0(wt0),
    .we1(we1), .wa1(wa1), .wn1(wn1), .wt1(wt1),
    .re1(re1), .ra1(ra1), .re2(re2), .ra2(ra2),
    .rn1(rn1), .rn2(rn2), .rb1(rb1), .rb2(rb2),
    .rt1(rt1), .rt2(rt2), .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input string tag);
    case (tag)
      "rn1":   return rn1;
      "rn2":   return rn2;
      "rb1":   return {31'd0, rb1};
      "rb2":   return {31'd0, rb2};
      "rt1":   return {28'd0, rt1};
      "rt2":   return {28'd0, rt2};
      "nbusy": return {26'd0, nbusy};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    eq.push_back(v);
  endtask

  // Wait for the falling edge, drain the scoreboard, then step past the next rising edge.
  task automatic settle_and_check();
    string       tag;
    logic [31:0] e, o;
    @(negedge clk);
    while (tq.size() > 0) begin
      tag = tq.pop_front();
      e   = eq.pop_front();
      o   = obs(tag);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss = 0; ia = 0; it = 0; fl = 0;
    we0 = 0; wa0 = 0; wn0 = 0; wt0 = 0;
    we1 = 0; wa1 = 0; wn1 = 0; wt1 = 0;
  endtask

  initial begin
    rst = 1; re1 = 1; ra1 = 5; re2 = 1; ra2 = 0;
    idle();
    @(posedge clk); #1;
    expect_v("rn1", 0); expect_v("rb1", 0);
    settle_and_check();
    rst = 0;

    // After reset: x5 and x0 read zero, nothing busy
    expect_v("rn1", 0); expect_v("rb1", 0); expect_v("rn2", 0); expect_v("nbusy", 0);
    settle_and_check();

    // Write x5, same-cycle bypass
    we0 = 1; wa0 = 5; wn0 = 32'hDEADBEEF;
    expect_v("rn1", 32'hDEADBEEF);
    settle_and_check();
    idle();
    re2 = 0; ra2 = 5;
    expect_v("rn1", 32'hDEADBEEF); expect_v("rn2", 0);
    settle_and_check();
    re2 = 1;

    // Issue x3 tag 7; not visible until after the edge
    iss = 1; ia = 3; it = 7; ra1 = 3;
    expect_v("rb1", 0); expect_v("nbusy", 0);
    settle_and_check();
    idle();
    we0 = 1; wa0 = 3; wt0 = 2; wn0 = 32'h99;
    expect_v("rb1", 1); expect_v("rt1", 7); expect_v("rn1", 0); expect_v("nbusy", 1);
    settle_and_check();
    idle();
    we1 = 1; wa1 = 3; wt1 = 7; wn1 = 32'h55;
    expect_v("rn1", 32'h55); expect_v("rb1", 0); expect_v("rt1", 0); expect_v("nbusy", 1);
    settle_and_check();
    idle();
    expect_v("rn1", 32'h55); expect_v("rb1", 0); expect_v("nbusy", 0);
    settle_and_check();

    // Both channels write x9: channel 1 wins
    we0 = 1; wa0 = 9; wn0 = 32'h11; we1 = 1; wa1 = 9; wn1 = 32'h22; ra2 = 9;
    expect_v("rn2", 32'h22);
    settle_and_check();
    idle();
    iss = 1; ia = 4; it = 0;
    expect_v("rn2", 32'h22);
    settle_and_check();

    // x4 busy tag 0: commit with tag 0 and re-issue with tag 1 together
    idle();
    iss = 1; ia = 4; it = 1; we0 = 1; wa0 = 4; wt0 = 0; wn0 = 32'h44; ra1 = 4;
    expect_v("rn1", 32'h44); expect_v("rb1", 0); expect_v("nbusy", 1);
    settle_and_check();
    idle();
    iss = 1; ia = 1; it = 1;
    expect_v("rn1", 32'h44); expect_v("rb1", 1); expect_v("rt1", 1); expect_v("nbusy", 1);
    settle_and_check();
    idle(); iss = 1; ia = 2; it = 2;
    settle_and_check();
    idle(); iss = 1; ia = 6; it = 6;
    settle_and_check();

    // Flush with a same-cycle issue of x7
    idle();
    fl = 1; iss = 1; ia = 7; it = 3; ra2 = 6;
    expect_v("nbusy", 4); expect_v("rb2", 1); expect_v("rt2", 6);
    settle_and_check();
    idle();
    iss = 1; ia = 0; it = 5; we0 = 1; wa0 = 0; wn0 = 32'hFF; ra1 = 7; ra2 = 4;
    expect_v("nbusy", 1); expect_v("rb1", 1); expect_v("rt1", 3);
    expect_v("rb2", 0); expect_v("rn2", 32'h44);
    settle_and_check();
    idle();
    we1 = 1; wa1 = 0; wn1 = 32'hAB; ra2 = 0;
    expect_v("rn2", 0); expect_v("rb2", 0); expect_v("rt2", 0); expect_v("nbusy", 1);
    settle_and_check();

    // Reset mid-stream overrides issue and write
    idle();
    rst = 1; iss = 1; ia = 8; it = 2; we0 = 1; wa0 = 10; wn0 = 32'h77; ra1 = 7; ra2 = 10;
    expect_v("rn1", 0); expect_v("rb1", 0); expect_v("rt1", 0); expect_v("rn2", 0);
    settle_and_check();
    rst = 0; idle();
    ra1 = 7; ra2 = 5;
    expect_v("nbusy", 0); expect_v("rb1", 0); expect_v("rn2", 0);
    settle_and_check();
    ra1 = 10; ra2 = 8;
    expect_v("rn1", 0); expect_v("rb2", 0); expect_v("rt2", 0);
    settle_and_check();
    ra1 = 9; ra2 = 4;
    expect_v("rn1", 0); expect_v("rn2", 0);
    settle_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
